seg_scan_capture: RTL and testbench
===================================

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 SHALL have parameter SETTLE, default 16, meaning the number of consecutive identical samples required before a digit is captured.
REQ-002 SHALL have parameter TIMEOUT_W, default 20, meaning the width of the scan-timeout counter; the timeout is 2^TIMEOUT_W cycles.
REQ-003 SHALL have port Clk100Mhz, input, 1 bit: the single clock, and the only one; every flop is clocked by its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port segIn, input, 8 bits: multiplexed active-low segment lines (bit 7 = dp), asynchronous to Clk100Mhz.
REQ-006 SHALL have port anIn, input, 4 bits: active-low digit anodes, asynchronous to Clk100Mhz.
REQ-007 SHALL have ports seg0, seg1, seg2 and seg3, outputs, 8 bits each: the last complete frame, one digit per port, with seg0 corresponding to anIn[0].
REQ-008 SHALL have port frameValid, output, 1 bit: a one-cycle pulse when a new complete frame is published.
REQ-009 SHALL have port digitSeen, output, 4 bits: the digits captured since the last publish.
REQ-010 SHALL have port anError, output, 1 bit: sticky flag, set when a multi-hot anode is detected.
REQ-011 SHALL have port stale, output, 1 bit: level, high while no capture has occurred within the timeout.

Function
REQ-012 SHALL pass segIn and anIn through a 2-flop synchronizer; all logic below uses the synchronized values (segS, anS).
REQ-013 SHALL implement an FSM with states IDLE, SETTLE and HELD.
REQ-014 IDLE: when anS is one-cold (exactly one bit low), SHALL record the selected index and segS, clear the settle counter, and go to SETTLE.
REQ-015 SETTLE: when anS is unchanged and segS is unchanged, SHALL increment the counter; when the counter reaches SETTLE-1, SHALL capture segS into digit[index], set digitSeen[index], and go to HELD.
REQ-016 SETTLE: if segS changes while anS is unchanged, SHALL reload the recorded segS and zero the counter, staying in SETTLE.
REQ-017 SETTLE or HELD: if anS changes to a different one-cold value, SHALL behave as IDLE in the same cycle (re-record, counter cleared, go to SETTLE).
REQ-018 Any state: if anS is all-ones (blanking), SHALL go to IDLE.
REQ-019 Any state: if anS has two or more low bits, SHALL set anError, go to IDLE, and capture nothing.
REQ-020 HELD: SHALL perform no recapture until anS changes, so each anode dwell yields exactly one capture.
REQ-021 When the capture makes digitSeen equal to 4'b1111, SHALL in the next cycle copy all four digit registers to seg0..seg3, pulse frameValid for one cycle, and clear digitSeen. Capture-to-frameValid latency is 1 cycle; input-to-capture latency is 2 + SETTLE cycles minimum.
REQ-022 If a digit is recaptured before the frame completes, SHALL overwrite it; the newest value wins.
REQ-023 If a capture coincides with the publish cycle, SHALL set that digit's digitSeen bit after the clear, so the digit counts toward the next frame.
REQ-024 SHALL clear the timeout counter on every capture and otherwise increment it, saturating at all-ones; stale SHALL be high exactly while the counter is saturated.
REQ-025 seg0..seg3 SHALL change only on a publish cycle.

Reset
REQ-026 On reset, SHALL drive seg0..seg3 and the internal digit registers to 8'hFF (all segments off).
REQ-027 On reset, SHALL clear frameValid, digitSeen and anError, and enter IDLE with the settle and timeout counters at zero.
REQ-028 On reset, SHALL load the synchronizer flops with 1s (idle-blank).
REQ-029 Reset asserted mid-SETTLE or mid-frame SHALL abandon the partial frame with no frameValid pulse; anError is cleared only by reset.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the blank constant 8'hFF, and the one-cold detect function.
REQ-031 SHALL use one sub-module, sync2, as a parameterized-width 2-flop synchronizer (reset value all-ones), instantiated once for {anIn, segIn}.

Verification
REQ-032 Bench SHALL scan anIn 1110/1101/1011/0111 with segIn C0, F9, A4, B0 and 64-cycle dwell -> one frameValid pulse; seg0..seg3 = C0, F9, A4, B0; digitSeen returns to 0.
REQ-033 Bench SHALL dwell on digit 0 with segIn toggling every 8 cycles (SETTLE=16) -> no capture; digitSeen[0] stays 0.
REQ-034 Bench SHALL drive anIn=1100 for 10 cycles, then a valid scan -> anError=1 and stays set; the frame still publishes correctly.
REQ-035 Bench SHALL assert reset after digits 0-2 are captured -> no frameValid, outputs FF, and the next full scan publishes normally.
REQ-036 Bench SHALL hold anIn=1111 with TIMEOUT_W=6 -> stale rises after 64 cycles and falls in the cycle after the next capture.
REQ-037 Bench SHALL rescan digit 1 with 92 before digits 2-3 complete -> the published seg1 = 92.

Source files
------------

// File: rtl/seg_scan_capture_pkg.sv
// Shared definitions for the seven-segment scan capture block.
//   state_t      : capture FSM state encoding
//   SegBlank     : all-segments-off pattern (segments are active-low)
//   is_one_cold  : true when exactly one anode line is driven low
//   cold_index   : position of the low anode line of a one-cold pattern
package seg_scan_capture_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StHeld   = 2'd2
    } state_t;

    localparam logic [7:0] SegBlank = 8'hFF;

    function automatic logic is_one_cold(input logic [3:0] an);
        return $countones(~an) == 1;
    endfunction

    function automatic logic [1:0] cold_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_capture_sync2.sv
// Two-flop synchronizer for a bus of asynchronous inputs.
//   clk : sampling clock
//   rst : asynchronous active-high reset, loads all-ones (idle-blank display)
//   d   : asynchronous input bus
//   q   : synchronized output bus
module sync2 #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures the four digits of a multiplexed seven-segment display and republishes
// them as a frame once every digit has been seen.
//   Clk100Mhz        : sole clock
//   reset            : asynchronous active-high reset
//   segIn, anIn      : asynchronous active-low segment and anode lines
//   seg0..seg3       : last complete frame (seg0 belongs to anIn[0])
//   frameValid       : one-cycle pulse when a new frame is published
//   digitSeen        : digits captured since the last publish
//   anError          : sticky, set on any multi-hot anode pattern
//   stale            : high while no capture has happened within 2^TIMEOUT_W cycles
module seg_scan_capture
    import seg_scan_capture_pkg::*;
#(
    parameter int unsigned SETTLE    = 16,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic       Clk100Mhz,
    input  logic       reset,
    input  logic [7:0] segIn,
    input  logic [3:0] anIn,
    output logic [7:0] seg0,
    output logic [7:0] seg1,
    output logic [7:0] seg2,
    output logic [7:0] seg3,
    output logic       frameValid,
    output logic [3:0] digitSeen,
    output logic       anError,
    output logic       stale
);

    localparam int unsigned CntW = $clog2(SETTLE) + 1;
    // The recorded sample counts as the first of SETTLE, so the capture fires on the
    // unchanged sample that would take the counter to SETTLE-1.
    localparam logic [CntW-1:0] CapAt = CntW'(SETTLE - 2);

    logic [11:0]          sync_q;
    logic [3:0]           an_s;
    logic [7:0]           seg_s;
    logic                 an_one_cold;
    logic                 an_blank;
    logic                 an_multi;
    logic [1:0]           an_idx;

    state_t               state;
    logic [3:0]           an_rec;
    logic [7:0]           seg_rec;
    logic [1:0]           idx;
    logic [CntW-1:0]      settle_cnt;
    logic [7:0]           digit [4];
    logic [TIMEOUT_W-1:0] tmo_cnt;

    logic                 capture;
    logic                 publish;
    logic [3:0]           seen_next;

    sync2 #(
        .Width(12)
    ) u_sync (
        .clk(Clk100Mhz),
        .rst(reset),
        .d  ({anIn, segIn}),
        .q  (sync_q)
    );

    assign an_s        = sync_q[11:8];
    assign seg_s       = sync_q[7:0];
    assign an_one_cold = is_one_cold(an_s);
    assign an_blank    = (an_s == 4'hF);
    assign an_multi    = !an_one_cold && !an_blank;
    assign an_idx      = cold_index(an_s);

    assign capture = (state == StSettle) && an_one_cold && (an_s == an_rec) &&
                     (seg_s == seg_rec) && (settle_cnt == CapAt);
    assign publish = (digitSeen == 4'hF);
    assign stale   = &tmo_cnt;

    // A capture in the publish cycle lands after the clear and counts toward the next frame.
    always_comb begin
        seen_next = publish ? 4'h0 : digitSeen;
        if (capture) seen_next[idx] = 1'b1;
    end

    always_ff @(posedge Clk100Mhz or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            an_rec     <= 4'hF;
            seg_rec    <= SegBlank;
            idx        <= 2'd0;
            settle_cnt <= '0;
            for (int i = 0; i < 4; i++) digit[i] <= SegBlank;
            seg0       <= SegBlank;
            seg1       <= SegBlank;
            seg2       <= SegBlank;
            seg3       <= SegBlank;
            frameValid <= 1'b0;
            digitSeen  <= 4'h0;
            anError    <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            frameValid <= publish;
            if (publish) begin
                seg0 <= digit[0];
                seg1 <= digit[1];
                seg2 <= digit[2];
                seg3 <= digit[3];
            end
            digitSeen <= seen_next;
            if (capture) digit[idx] <= seg_s;

            if (capture) begin
                tmo_cnt <= '0;
            end else if (!stale) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (an_multi) begin
                anError <= 1'b1;
                state   <= StIdle;
            end else if (an_blank) begin
                state <= StIdle;
            end else if (state == StIdle || an_s != an_rec) begin
                // New anode dwell: start settling on the current pattern.
                an_rec     <= an_s;
                seg_rec    <= seg_s;
                idx        <= an_idx;
                settle_cnt <= '0;
                state      <= StSettle;
            end else if (state == StSettle) begin
                if (seg_s != seg_rec) begin
                    seg_rec    <= seg_s;
                    settle_cnt <= '0;
                end else if (capture) begin
                    state <= StHeld;
                end else begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
            end
            // StHeld with the same anode: wait for the anode to change.
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed scenarios plus randomized scanning,
// checked every cycle against a dwell/run-length model of the capture rules.
module tb_seg_scan_capture;

    localparam int unsigned SETTLE    = 16;
    localparam int unsigned TIMEOUT_W = 6;
    localparam int          TMO_MAX   = (1 << TIMEOUT_W) - 1;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] seg_in = 8'hFF;
    logic [3:0] an_in  = 4'hF;
    logic [7:0] seg0, seg1, seg2, seg3;
    logic       frame_valid;
    logic [3:0] digit_seen;
    logic       an_error;
    logic       stale;

    always #5 clk = ~clk;

    seg_scan_capture #(
        .SETTLE   (SETTLE),
        .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .Clk100Mhz (clk),
        .reset     (reset),
        .segIn     (seg_in),
        .anIn      (an_in),
        .seg0      (seg0),
        .seg1      (seg1),
        .seg2      (seg2),
        .seg3      (seg3),
        .frameValid(frame_valid),
        .digitSeen (digit_seen),
        .anError   (an_error),
        .stale     (stale)
    );

    int n_pass   = 0;
    int n_total  = 0;
    int fv_count = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    // A dwell is a run of samples on one one-cold anode; the first run of SETTLE identical
    // segment samples in a dwell produces its single capture.
    logic [11:0] m_pipe [2];
    bit          m_in_dwell;
    logic [3:0]  m_an;
    logic [7:0]  m_run_seg;
    int          m_run_len;
    bit          m_done;
    logic [7:0]  m_digit [4];
    logic [7:0]  m_out [4];
    bit          m_fv;
    logic [3:0]  m_seen;
    bit          m_err;
    int          m_tmo;

    task automatic model_reset();
        m_pipe[0] = 12'hFFF;
        m_pipe[1] = 12'hFFF;
        m_in_dwell = 1'b0;
        m_an = 4'hF;
        m_run_seg = 8'hFF;
        m_run_len = 0;
        m_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_digit[i] = 8'hFF;
            m_out[i] = 8'hFF;
        end
        m_fv = 1'b0;
        m_seen = 4'h0;
        m_err = 1'b0;
        m_tmo = 0;
    endtask

    task automatic model_step(input logic [3:0] ai, input logic [7:0] si);
        logic [3:0] a;
        logic [7:0] s;
        int zeros;
        int ci;
        bit cap;
        bit pub;
        a = m_pipe[1][11:8];
        s = m_pipe[1][7:0];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = {ai, si};
        zeros = 4 - $countones(a);
        cap = 1'b0;
        pub = (m_seen == 4'hF);
        ci = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) ci = i;
        if (zeros >= 2) begin
            m_err = 1'b1;
            m_in_dwell = 1'b0;
        end else if (zeros == 0) begin
            m_in_dwell = 1'b0;
        end else if (!m_in_dwell || a != m_an) begin
            m_in_dwell = 1'b1;
            m_an = a;
            m_run_seg = s;
            m_run_len = 1;
            m_done = 1'b0;
        end else if (!m_done) begin
            if (s != m_run_seg) begin
                m_run_seg = s;
                m_run_len = 1;
            end else begin
                m_run_len++;
                if (m_run_len == SETTLE) begin
                    cap = 1'b1;
                    m_done = 1'b1;
                end
            end
        end
        m_fv = pub;
        if (pub) begin
            for (int i = 0; i < 4; i++) m_out[i] = m_digit[i];
            m_seen = 4'h0;
        end
        if (cap) begin
            m_digit[ci] = s;
            m_seen[ci] = 1'b1;
            m_tmo = 0;
        end else if (m_tmo < TMO_MAX) begin
            m_tmo++;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) model_reset();
        else model_step(an_in, seg_in);
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(posedge clk);
        #3;
        if (chk_en) begin
            check("seg0", seg0, m_out[0]);
            check("seg1", seg1, m_out[1]);
            check("seg2", seg2, m_out[2]);
            check("seg3", seg3, m_out[3]);
            check("frameValid", frame_valid, m_fv);
            check("digitSeen", digit_seen, m_seen);
            check("anError", an_error, m_err);
            check("stale", stale, m_tmo == TMO_MAX);
            if (frame_valid) fv_count++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        an_in = a;
        seg_in = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_digit(input int i, input logic [7:0] s, input int dwell);
        logic [3:0] a;
        a = 4'hF;
        a[i] = 1'b0;
        hold(a, s, dwell);
    endtask

    task automatic check_frame(input string name, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        check({name, "_seg0"}, seg0, e0);
        check({name, "_seg1"}, seg1, e1);
        check({name, "_seg2"}, seg2, e2);
        check({name, "_seg3"}, seg3, e3);
    endtask

    initial begin
        int fv0;
        logic [3:0] a;
        logic [7:0] s;

        repeat (3) @(negedge clk);
        check_frame("reset", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        check("reset_fv", frame_valid, 1'b0);
        check("reset_seen", digit_seen, 4'h0);
        check("reset_anerr", an_error, 1'b0);
        check("reset_stale", stale, 1'b0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Blank display: stale rises once the 6-bit timeout saturates.
        hold(4'hF, 8'hFF, 62);
        check("stale_early", stale, 1'b0);
        hold(4'hF, 8'hFF, 2);
        check("stale_rise", stale, 1'b1);

        // Full scan; first digit pins the 2 + SETTLE capture latency and stale falling.
        fv0 = fv_count;
        scan_digit(0, 8'hC0, 17);
        check("pre_capture_seen", digit_seen, 4'h0);
        check("pre_capture_stale", stale, 1'b1);
        scan_digit(0, 8'hC0, 1);
        check("capture_seen", digit_seen, 4'h1);
        check("capture_stale", stale, 1'b0);
        scan_digit(0, 8'hC0, 46);
        scan_digit(1, 8'hF9, 64);
        scan_digit(2, 8'hA4, 64);
        scan_digit(3, 8'hB0, 64);
        hold(4'hF, 8'hFF, 4);
        check("scan_fv_pulses", fv_count - fv0, 1);
        check_frame("scan", 8'hC0, 8'hF9, 8'hA4, 8'hB0);
        check("scan_seen_cleared", digit_seen, 4'h0);

        // Segment lines never settle long enough on digit 0.
        for (int k = 0; k < 8; k++) scan_digit(0, k[0] ? 8'h22 : 8'h11, 8);
        check("bounce_no_capture", digit_seen[0], 1'b0);
        hold(4'hF, 8'hFF, 4);

        // Multi-hot anode sets the sticky error; the following scan still publishes.
        fv0 = fv_count;
        hold(4'b1100, 8'h55, 10);
        check("anerr_set", an_error, 1'b1);
        check("anerr_no_capture", digit_seen, 4'h0);
        scan_digit(0, 8'h8E, 32);
        scan_digit(1, 8'h86, 32);
        scan_digit(2, 8'hA1, 32);
        scan_digit(3, 8'hC6, 32);
        hold(4'hF, 8'hFF, 4);
        check("anerr_sticky", an_error, 1'b1);
        check("anerr_fv", fv_count - fv0, 1);
        check_frame("anerr", 8'h8E, 8'h86, 8'hA1, 8'hC6);

        // Reset mid-frame abandons the partial frame.
        fv0 = fv_count;
        scan_digit(0, 8'h01, 32);
        scan_digit(1, 8'h02, 32);
        scan_digit(2, 8'h03, 32);
        check("partial_seen", digit_seen, 4'h7);
        an_in = 4'hF;
        seg_in = 8'hFF;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_frame("midreset", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        check("midreset_seen", digit_seen, 4'h0);
        check("midreset_anerr", an_error, 1'b0);
        reset = 1'b0;
        hold(4'hF, 8'hFF, 4);
        check("midreset_no_fv", fv_count - fv0, 0);
        scan_digit(0, 8'h40, 32);
        scan_digit(1, 8'h79, 32);
        scan_digit(2, 8'h24, 32);
        scan_digit(3, 8'h30, 32);
        hold(4'hF, 8'hFF, 4);
        check("postreset_fv", fv_count - fv0, 1);
        check_frame("postreset", 8'h40, 8'h79, 8'h24, 8'h30);

        // Digit 1 rescanned before the frame completes: newest value wins.
        fv0 = fv_count;
        scan_digit(0, 8'hC0, 32);
        scan_digit(1, 8'hF9, 32);
        scan_digit(2, 8'hA4, 32);
        scan_digit(1, 8'h92, 32);
        scan_digit(3, 8'hB0, 32);
        hold(4'hF, 8'hFF, 4);
        check("rescan_fv", fv_count - fv0, 1);
        check_frame("rescan", 8'hC0, 8'h92, 8'hA4, 8'hB0);

        // Randomized scanning with glitches, blanking and occasional multi-hot anodes.
        for (int k = 0; k < 300; k++) begin
            int mode;
            int len;
            mode = $urandom_range(0, 19);
            len = $urandom_range(4, 40);
            s = 8'($urandom);
            if (mode == 0) begin
                a = 4'hF;
            end else if (mode == 1) begin
                do a = 4'($urandom); while ($countones(a) > 2);
            end else begin
                a = 4'hF;
                a[$urandom_range(0, 3)] = 1'b0;
            end
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 15) == 0) s = 8'($urandom);
                an_in = a;
                seg_in = s;
                @(negedge clk);
            end
        end
        hold(4'hF, 8'hFF, 4);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
